memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 34 +++
 rtl/memory_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the word RAM.
// slave = arbiter side, master = requesters plus RAM model side.
interface memory_arbiter_if;
  logic [15:0] fetchAddress;
  logic        fetchRequest;
  logic        fetchDone;
  logic [15:0] fetchReadData;
  logic [15:0] dataAddress;
  logic        dataRequest;
  logic        dataWrite;
  logic [15:0] dataWriteData;
  logic        dataDone;
  logic [15:0] dataReadData;
  logic [14:0] ramAddress;
  logic        ramEnable;
  logic        ramWriteEnable;
  logic [15:0] ramWriteData;
  logic [15:0] ramReadData;
  logic        alignError;

  modport slave (
    input  fetchAddress, fetchRequest, dataAddress, dataRequest, dataWrite,
           dataWriteData, ramReadData,
    output fetchDone, fetchReadData, dataDone, dataReadData, ramAddress,
           ramEnable, ramWriteEnable, ramWriteData, alignError
  );

  modport master (
    output fetchAddress, fetchRequest, dataAddress, dataRequest, dataWrite,
           dataWriteData, ramReadData,
    input  fetchDone, fetchReadData, dataDone, dataReadData, ramAddress,
           ramEnable, ramWriteEnable, ramWriteData, alignError
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) alternating-priority arbiter in front of a single-port word RAM.
// Optional MEM_ARB_ALIGN_CHECK_EN: odd byte addresses skip the RAM, read 16'hFFFF, set alignError.
module memory_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input logic             clk,
  input logic             reset,
  memory_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, CAPTURE, DONE} state_t;

  // Counter counts down to 0 inside WAIT, so it is loaded with one less than the wait length.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      r_state, w_state;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_last_data, w_last_data;
  logic        r_gnt_data, w_gnt_data;
  logic        r_wr, w_wr;
  logic        r_mis, w_mis;
  logic [14:0] r_ram_addr, w_ram_addr;
  logic        r_ram_en, w_ram_en;
  logic        r_ram_we, w_ram_we;
  logic [15:0] r_ram_wdata, w_ram_wdata;
  logic        r_fetch_done, w_fetch_done;
  logic        r_data_done, w_data_done;
  logic [15:0] r_fetch_rdata, w_fetch_rdata;
  logic [15:0] r_data_rdata, w_data_rdata;
  logic        r_align_err, w_align_err;

  logic        w_pick_data;
  logic [15:0] w_addr;
  logic        w_addr_odd;
  logic [15:0] w_rd_val;

  // Data wins a tie only when fetch was granted last.
  assign w_pick_data = bus.dataRequest && (!bus.fetchRequest || r_last_data == 1'b0);
  assign w_addr      = w_pick_data ? bus.dataAddress : bus.fetchAddress;
  assign w_rd_val    = r_mis ? 16'hFFFF : bus.ramReadData;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign w_addr_odd = w_addr[0];
`else
  logic w_unused_addr0;
  assign w_unused_addr0 = w_addr[0];
  assign w_addr_odd     = 1'b0;
`endif

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_last_data   = r_last_data;
    w_gnt_data    = r_gnt_data;
    w_wr          = r_wr;
    w_mis         = r_mis;
    w_ram_addr    = r_ram_addr;
    w_ram_wdata   = r_ram_wdata;
    w_fetch_rdata = r_fetch_rdata;
    w_data_rdata  = r_data_rdata;
    w_align_err   = r_align_err;
    w_ram_en      = 1'b0;
    w_ram_we      = 1'b0;
    w_fetch_done  = 1'b0;
    w_data_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.fetchRequest || bus.dataRequest) begin
          w_state     = ACCESS;
          w_gnt_data  = w_pick_data;
          w_last_data = w_pick_data;
          w_wr        = w_pick_data && bus.dataWrite;
          w_mis       = w_addr_odd;
          w_ram_addr  = w_addr[15:1];
          w_ram_wdata = bus.dataWriteData;
          w_ram_en    = !w_addr_odd;
          w_ram_we    = !w_addr_odd && w_pick_data && bus.dataWrite;
          if (w_addr_odd) w_align_err = 1'b1;
        end
      end
      ACCESS: begin
        if (WAIT_STATES > 0) begin
          w_state = WAIT;
          w_cnt   = WAIT_LOAD;
        end else begin
          w_state = CAPTURE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_state = CAPTURE;
        else               w_cnt   = r_cnt - 4'd1;
      end
      CAPTURE: begin
        if (!r_wr) begin
          if (r_gnt_data) w_data_rdata  = w_rd_val;
          else            w_fetch_rdata = w_rd_val;
        end
        // Done is raised here so the registered pulse lands in the DONE cycle.
        w_fetch_done = !r_gnt_data;
        w_data_done  = r_gnt_data;
        w_state      = DONE;
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_last_data   <= 1'b0;
      r_gnt_data    <= 1'b0;
      r_wr          <= 1'b0;
      r_mis         <= 1'b0;
      r_ram_addr    <= 15'h0;
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_wdata   <= 16'h0000;
      r_fetch_done  <= 1'b0;
      r_data_done   <= 1'b0;
      r_fetch_rdata <= 16'h0000;
      r_data_rdata  <= 16'h0000;
      r_align_err   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_last_data   <= w_last_data;
      r_gnt_data    <= w_gnt_data;
      r_wr          <= w_wr;
      r_mis         <= w_mis;
      r_ram_addr    <= w_ram_addr;
      r_ram_en      <= w_ram_en;
      r_ram_we      <= w_ram_we;
      r_ram_wdata   <= w_ram_wdata;
      r_fetch_done  <= w_fetch_done;
      r_data_done   <= w_data_done;
      r_fetch_rdata <= w_fetch_rdata;
      r_data_rdata  <= w_data_rdata;
      r_align_err   <= w_align_err;
    end
  end

  assign bus.ramAddress     = r_ram_addr;
  assign bus.ramEnable      = r_ram_en;
  assign bus.ramWriteEnable = r_ram_we;
  assign bus.ramWriteData   = r_ram_wdata;
  assign bus.fetchDone      = r_fetch_done;
  assign bus.dataDone       = r_data_done;
  assign bus.fetchReadData  = r_fetch_rdata;
  assign bus.dataReadData   = r_data_rdata;
  assign bus.alignError     = r_align_err;
endmodule
